// File: rtl/gshare_index_gen.sv
// Gshare front end: speculative/committed global history, fetch-side PHT index,
// and an in-flight branch FIFO that returns the fetch index for PHT training.
module gshare_index_gen #(
  parameter int unsigned IDX_W = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_pc,
  input  logic                       fetch_is_br,
  input  logic                       pred_taken,
  output logic                       fetch_ready,
  output logic [IDX_W-1:0]           pht_idx,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       mispredict,
  output logic                       upd_en,
  output logic [IDX_W-1:0]           upd_idx,
  output logic                       upd_taken,
  output logic [IDX_W-1:0]           spec_ghr,
  output logic [IDX_W-1:0]           arch_ghr,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic                       err_underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] spec_ghr_q, spec_ghr_d;
  logic [IDX_W-1:0] arch_ghr_q, arch_ghr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd_en_q, upd_en_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             upd_taken_q, upd_taken_d;
  logic             err_q, err_d;

  // Only the low IDX_W-1 history bits survive the repair shift, so only those are kept.
  logic [IDX_W-1:0] fifo_idx_q  [DEPTH];
  logic [IDX_W-1:0] fifo_idx_d  [DEPTH];
  logic [IDX_W-2:0] fifo_ghr_q  [DEPTH];
  logic [IDX_W-2:0] fifo_ghr_d  [DEPTH];
  logic             fifo_pred_q [DEPTH];
  logic             fifo_pred_d [DEPTH];

  logic             push;
  logic             pop;
  logic             empty;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-2:0] head_ghr;
  logic             head_pred;
  logic             unused_pc;

  assign unused_pc = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

  always_comb begin
    empty       = (cnt_q == '0);
    fetch_ready = (cnt_q != CNT_W'(DEPTH));
    pht_idx     = fetch_pc[IDX_W+1:2] ^ spec_ghr_q;
    head_idx    = fifo_idx_q[rd_ptr_q];
    head_ghr    = fifo_ghr_q[rd_ptr_q];
    head_pred   = fifo_pred_q[rd_ptr_q];
    push        = fetch_valid & fetch_is_br & fetch_ready;
    pop         = res_valid & ~empty;
    mispredict  = pop & (head_pred != res_taken);
  end

  always_comb begin
    spec_ghr_d  = spec_ghr_q;
    arch_ghr_d  = arch_ghr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    fifo_idx_d  = fifo_idx_q;
    fifo_ghr_d  = fifo_ghr_q;
    fifo_pred_d = fifo_pred_q;
    upd_en_d    = pop;
    upd_idx_d   = upd_idx_q;
    upd_taken_d = upd_taken_q;
    err_d       = err_q | (res_valid & empty);

    if (pop) begin
      arch_ghr_d  = {arch_ghr_q[IDX_W-2:0], res_taken};
      upd_idx_d   = head_idx;
      upd_taken_d = res_taken;
    end

    if (mispredict) begin
      // Flush wins over any same-cycle push; history rebuilt from the head snapshot.
      spec_ghr_d = {head_ghr, res_taken};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end else begin
      if (push) begin
        fifo_idx_d[wr_ptr_q]  = pht_idx;
        fifo_ghr_d[wr_ptr_q]  = spec_ghr_q[IDX_W-2:0];
        fifo_pred_d[wr_ptr_q] = pred_taken;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        spec_ghr_d            = {spec_ghr_q[IDX_W-2:0], pred_taken};
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_ghr_q  <= '0;
      arch_ghr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      upd_en_q    <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
      err_q       <= 1'b0;
      fifo_idx_q  <= '{default: '0};
      fifo_ghr_q  <= '{default: '0};
      fifo_pred_q <= '{default: 1'b0};
    end else begin
      spec_ghr_q  <= spec_ghr_d;
      arch_ghr_q  <= arch_ghr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      upd_en_q    <= upd_en_d;
      upd_idx_q   <= upd_idx_d;
      upd_taken_q <= upd_taken_d;
      err_q       <= err_d;
      fifo_idx_q  <= fifo_idx_d;
      fifo_ghr_q  <= fifo_ghr_d;
      fifo_pred_q <= fifo_pred_d;
    end
  end

  assign spec_ghr      = spec_ghr_q;
  assign arch_ghr      = arch_ghr_q;
  assign inflight      = cnt_q;
  assign upd_en        = upd_en_q;
  assign upd_idx       = upd_idx_q;
  assign upd_taken     = upd_taken_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_gshare_index_gen.sv
// Directed bench for gshare_index_gen: hand-computed indices, history and FIFO occupancy.
module tb_gshare_index_gen;

  localparam int unsigned IDX_W = 12;
  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_valid;
  logic [31:0]       fetch_pc;
  logic              fetch_is_br;
  logic              pred_taken;
  logic              fetch_ready;
  logic [IDX_W-1:0]  pht_idx;
  logic              res_valid;
  logic              res_taken;
  logic              mispredict;
  logic              upd_en;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic [IDX_W-1:0]  spec_ghr;
  logic [IDX_W-1:0]  arch_ghr;
  logic [2:0]        inflight;
  logic              err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  gshare_index_gen #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_is_br   (fetch_is_br),
    .pred_taken    (pred_taken),
    .fetch_ready   (fetch_ready),
    .pht_idx       (pht_idx),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .mispredict    (mispredict),
    .upd_en        (upd_en),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .spec_ghr      (spec_ghr),
    .arch_ghr      (arch_ghr),
    .inflight      (inflight),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    fetch_valid = 1'b0;
    fetch_is_br = 1'b0;
    fetch_pc    = '0;
    pred_taken  = 1'b0;
    res_valid   = 1'b0;
    res_taken   = 1'b0;
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_br(input logic [31:0] pc, input logic pred, input logic [31:0] exp_idx);
    fetch_valid = 1'b1;
    fetch_is_br = 1'b1;
    fetch_pc    = pc;
    pred_taken  = pred;
    #1;
    check_eq("push_pht_idx", 32'(pht_idx), exp_idx);
    check_eq("push_ready", 32'(fetch_ready), 32'd1);
    step();
    clear_inputs();
  endtask

  task automatic resolve(input logic taken, input logic exp_mp);
    res_valid = 1'b1;
    res_taken = taken;
    #1;
    check_eq("mispredict", 32'(mispredict), 32'(exp_mp));
    step();
    clear_inputs();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset values, visible while reset is held
    #2;
    check_eq("rst_spec_ghr", 32'(spec_ghr), 32'h000);
    check_eq("rst_arch_ghr", 32'(arch_ghr), 32'h000);
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    check_eq("rst_upd_en", 32'(upd_en), 32'd0);
    check_eq("rst_upd_idx", 32'(upd_idx), 32'h000);
    check_eq("rst_err", 32'(err_underflow), 32'd0);
    check_eq("rst_ready", 32'(fetch_ready), 32'd1);
    fetch_pc = 32'h40;
    #1;
    check_eq("rst_pht_idx", 32'(pht_idx), 32'h010);
    step();
    rst = 1'b0;
    clear_inputs();

    // Three pushes (1,0,1) then a correctly predicted resolve
    push_br(32'h100, 1'b1, 32'h040);
    push_br(32'h200, 1'b0, 32'h081);
    push_br(32'h300, 1'b1, 32'h0C2);
    check_eq("t2_spec_ghr", 32'(spec_ghr), 32'h005);
    check_eq("t2_inflight", 32'(inflight), 32'd3);
    check_eq("t2_upd_en_idle", 32'(upd_en), 32'd0);
    resolve(1'b1, 1'b0);
    check_eq("t2_upd_en", 32'(upd_en), 32'd1);
    check_eq("t2_upd_idx", 32'(upd_idx), 32'h040);
    check_eq("t2_upd_taken", 32'(upd_taken), 32'd1);
    check_eq("t2_arch_ghr", 32'(arch_ghr), 32'h001);
    check_eq("t2_inflight_pop", 32'(inflight), 32'd2);
    check_eq("t2_spec_hold", 32'(spec_ghr), 32'h005);
    step();
    check_eq("t2_upd_en_drop", 32'(upd_en), 32'd0);
    check_eq("t2_upd_idx_hold", 32'(upd_idx), 32'h040);

    // Mispredict with a same-cycle push: flush, push discarded
    pulse_reset();
    push_br(32'h100, 1'b1, 32'h040);
    push_br(32'h200, 1'b0, 32'h081);
    push_br(32'h300, 1'b1, 32'h0C2);
    check_eq("t3_inflight", 32'(inflight), 32'd3);
    res_valid   = 1'b1;
    res_taken   = 1'b0;
    fetch_valid = 1'b1;
    fetch_is_br = 1'b1;
    fetch_pc    = 32'h400;
    pred_taken  = 1'b1;
    #1;
    check_eq("t3_mispredict", 32'(mispredict), 32'd1);
    step();
    clear_inputs();
    check_eq("t3_inflight_flush", 32'(inflight), 32'd0);
    check_eq("t3_spec_ghr", 32'(spec_ghr), 32'h000);
    check_eq("t3_arch_ghr", 32'(arch_ghr), 32'h000);
    check_eq("t3_upd_en", 32'(upd_en), 32'd1);
    check_eq("t3_upd_idx", 32'(upd_idx), 32'h040);
    check_eq("t3_upd_taken", 32'(upd_taken), 32'd0);
    check_eq("t3_ready", 32'(fetch_ready), 32'd1);

    // Fill to DEPTH, fifth branch held off, then pop/push around full
    push_br(32'h10, 1'b0, 32'h004);
    push_br(32'h20, 1'b0, 32'h008);
    push_br(32'h30, 1'b0, 32'h00C);
    push_br(32'h40, 1'b0, 32'h010);
    check_eq("t4_inflight_full", 32'(inflight), 32'd4);
    check_eq("t4_ready_full", 32'(fetch_ready), 32'd0);
    fetch_valid = 1'b1;
    fetch_is_br = 1'b1;
    fetch_pc    = 32'h50;
    pred_taken  = 1'b1;
    step();
    check_eq("t4_fifth_ignored", 32'(inflight), 32'd4);
    check_eq("t4_fifth_spec", 32'(spec_ghr), 32'h000);
    res_valid = 1'b1;
    res_taken = 1'b0;
    #1;
    check_eq("t4_full_mp", 32'(mispredict), 32'd0);
    check_eq("t4_full_ready", 32'(fetch_ready), 32'd0);
    step();
    check_eq("t4_full_pop_cnt", 32'(inflight), 32'd3);
    check_eq("t4_full_pop_spec", 32'(spec_ghr), 32'h000);
    check_eq("t4_full_pop_idx", 32'(upd_idx), 32'h004);
    check_eq("t4_full_pop_en", 32'(upd_en), 32'd1);
    #1;
    check_eq("t4_pp_ready", 32'(fetch_ready), 32'd1);
    check_eq("t4_pp_pht_idx", 32'(pht_idx), 32'h014);
    check_eq("t4_pp_mp", 32'(mispredict), 32'd0);
    step();
    clear_inputs();
    check_eq("t4_pp_inflight", 32'(inflight), 32'd3);
    check_eq("t4_pp_spec", 32'(spec_ghr), 32'h001);
    check_eq("t4_pp_upd_idx", 32'(upd_idx), 32'h008);
    check_eq("t4_pp_arch", 32'(arch_ghr), 32'h000);
    // Head now has pred 0 and fetch history 0; resolving taken repairs to 0x001
    resolve(1'b1, 1'b1);
    check_eq("t4_flush_cnt", 32'(inflight), 32'd0);
    check_eq("t4_flush_spec", 32'(spec_ghr), 32'h001);
    check_eq("t4_flush_arch", 32'(arch_ghr), 32'h001);
    check_eq("t4_flush_idx", 32'(upd_idx), 32'h00C);
    check_eq("t4_flush_taken", 32'(upd_taken), 32'd1);

    // Resolve with empty FIFO
    resolve(1'b0, 1'b0);
    check_eq("t5_err", 32'(err_underflow), 32'd1);
    check_eq("t5_upd_en", 32'(upd_en), 32'd0);
    check_eq("t5_arch_hold", 32'(arch_ghr), 32'h001);
    check_eq("t5_upd_idx_hold", 32'(upd_idx), 32'h00C);
    check_eq("t5_upd_taken_hold", 32'(upd_taken), 32'd1);
    step();
    check_eq("t5_err_sticky", 32'(err_underflow), 32'd1);

    // Async reset mid-cycle with two branches in flight and a training pulse live
    push_br(32'h100, 1'b1, 32'h041);
    push_br(32'h200, 1'b1, 32'h083);
    push_br(32'h300, 1'b1, 32'h0C7);
    check_eq("t6_spec_ghr", 32'(spec_ghr), 32'h00F);
    resolve(1'b1, 1'b0);
    check_eq("t6_inflight", 32'(inflight), 32'd2);
    check_eq("t6_arch_ghr", 32'(arch_ghr), 32'h003);
    check_eq("t6_upd_idx", 32'(upd_idx), 32'h041);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_spec", 32'(spec_ghr), 32'h000);
    check_eq("t6_rst_arch", 32'(arch_ghr), 32'h000);
    check_eq("t6_rst_inflight", 32'(inflight), 32'd0);
    check_eq("t6_rst_upd_en", 32'(upd_en), 32'd0);
    check_eq("t6_rst_upd_idx", 32'(upd_idx), 32'h000);
    check_eq("t6_rst_upd_taken", 32'(upd_taken), 32'd0);
    check_eq("t6_rst_err", 32'(err_underflow), 32'd0);
    check_eq("t6_rst_ready", 32'(fetch_ready), 32'd1);
    #1;
    rst = 1'b0;
    step();
    check_eq("t6_post_upd_en", 32'(upd_en), 32'd0);
    check_eq("t6_post_inflight", 32'(inflight), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
